play_arbiter: RTL
=================

# play_arbiter

Round-robin scheduler that shares the single track-playback datapath among three request sources. It latches request edges into a pending set and grants the datapath to one source at a time by driving the one-hot cv select. It holds the grant until the datapath reports done, an abort arrives, or a watchdog expires, then enforces a silent gap before the next grant. It sits between the front-panel request logic and the playback datapath, replacing the fixed-order sequencing used so far.

## Interface
- TIMEOUT_CYCLES, 1000000: maximum BUSY duration in clk cycles before the watchdog fires; must be ≥ 2.
- GAP_CYCLES, 16: number of cycles cv is forced to 0 between grants; must be ≥ 1.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req  input  3  per-source play request, synchronous level; a rising edge registers a request.
- abort  input  1  synchronous; ends the current grant immediately.
- done  input  1  datapath completion strobe; sampled only in BUSY.
- cv  output  3  registered one-hot datapath select: source 0 = 3'b100, source 1 = 3'b010, source 2 = 3'b001; 0 when no grant.
- busy  output  1  registered; 1 while in BUSY.
- pend  output  3  registered pending-request set, bit i for source i.
- timeout_err  output  1  sticky watchdog flag; cleared only by reset.

## Operation
- Reset values: cv=0, busy=0, pend=0, timeout_err=0, state=IDLE, last-served pointer ptr=2 (source 0 has first priority), req history=0. A req held high at reset release therefore counts as a rising edge.
- Edge detect: a rising edge on req[i] (req[i]=1, previous sample 0) sets pend[i]. An edge for a source that is already pending is absorbed, with no counting.
- States: IDLE, BUSY, GAP.
- IDLE: if pend≠0, select the first set bit in order ptr+1, ptr+2, ptr (mod 3). Load cv with that source's code, set busy, clear the watchdog counter, and go to BUSY. Otherwise stay, with cv=0.
- BUSY: cv and busy are held. The watchdog counter increments each cycle.
  - done=1: clear the served pend bit, set ptr=served, go to GAP.
  - abort=1 (done=0): same actions as done.
  - If the counter reaches TIMEOUT_CYCLES-1 without done or abort: set timeout_err, then perform the same actions as done.
- Priority in BUSY: done > abort > timeout.
- A req edge for the served source during BUSY sets its pend bit after that source's pend clear, so a replay request is not lost. The rule is set-wins if the edge coincides with the clearing cycle.
- GAP: cv=0, busy=0. Count GAP_CYCLES cycles, then go to IDLE.
- done and abort are ignored in IDLE and GAP.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES). Gap counter width is $clog2(GAP_CYCLES+1). Neither counter wraps, because each is cleared on state entry.
- An asynchronous reset mid-BUSY drops cv to 0 immediately and discards all pending requests.

## Timing
- A req edge sampled at clock edge n makes pend visible after edge n.
- If the arbiter is IDLE, cv/busy assert after edge n+1: a 2-cycle request-to-grant latency.
- done sampled high at edge m: cv=0 and busy=0 after edge m. The next grant's cv asserts after edge m+GAP_CYCLES+1 at the earliest.
- Watchdog: BUSY lasts exactly TIMEOUT_CYCLES cycles when no done or abort arrives. timeout_err rises on the same edge that cv clears.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package play_pkg holds:
  - the state enum (IDLE, BUSY, GAP);
  - N_SRC=3;
  - cv codes CV_SRC0=3'b100, CV_SRC1=3'b010, CV_SRC2=3'b001;
  - CV_NONE=3'b000.
- Sub-module rr_select3 is a purely combinational round-robin picker. It takes pend and ptr and returns a valid flag and a 2-bit index. It is instantiated once.
- The rest is a single FSM process plus the counter and pend registers.

## Test plan
- Reset release with req=0, then a req[0] edge: pend=3'b001 after 1 cycle, cv=3'b100 and busy=1 after 2 cycles; done pulse gives cv=0, then GAP_CYCLES cycles at 0.
- Round-robin: req edges on all three sources in the same cycle. Grants occur in order 0, 1, 2 (cv 100, 010, 001), each separated by GAP_CYCLES idle cycles; pend drains 111→110→100→000.
- Fairness: after source 1 is served, req edges on 0 and 1 together. The next grant is source 0 (order 2, 0, 1 from ptr=1), and source 1 is granted only after that.
- Watchdog with TIMEOUT_CYCLES=8: grant with no done. cv clears after exactly 8 BUSY cycles, timeout_err=1 and stays 1 through later normal grants.
- Simultaneous events: done and abort in the same cycle give a normal completion. A req edge on the served source in its done cycle leaves pend for that source set, and it is re-granted after the gap.
- Async reset asserted mid-BUSY gives cv=0, busy=0, pend=0 with no clock edge; after release, grant priority restarts at source 0.

Source files
------------

// File: rtl/play_pkg.sv
// rtl/play_pkg.sv - shared types and constants for the playback arbiter
package play_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_t;

    localparam int N_SRC = 3;

    localparam logic [2:0] CV_SRC0 = 3'b100;
    localparam logic [2:0] CV_SRC1 = 3'b010;
    localparam logic [2:0] CV_SRC2 = 3'b001;
    localparam logic [2:0] CV_NONE = 3'b000;

    function automatic logic [2:0] cv_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return CV_SRC0;
            2'd1:    return CV_SRC1;
            default: return CV_SRC2;
        endcase
    endfunction

    // Modulo-3 increment on a 2-bit source index.
    function automatic logic [1:0] inc3(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_select3.sv
// rtl/rr_select3.sv - combinational round-robin picker over three pending sources
module rr_select3
    import play_pkg::*;
(
    input  logic [2:0] pend_i,
    input  logic [1:0] ptr_i,
    output logic       valid_o,
    output logic [1:0] idx_o
);

    logic [1:0] cand;

    // Search order ptr+1, ptr+2, ptr so the last-served source goes last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int k = 0; k < N_SRC; k++) begin
            cand = inc3(cand);
            if (!valid_o && pend_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/play_arbiter.sv
// rtl/play_arbiter.sv - round-robin grant of the playback datapath with watchdog and gap
module play_arbiter
    import play_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       abort,
    input  logic       done,
    output logic [2:0] cv,
    output logic       busy,
    output logic [2:0] pend,
    output logic       timeout_err
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t            state_q;
    logic [2:0]        cv_q;
    logic              busy_q;
    logic [2:0]        pend_q;
    logic [2:0]        pend_d;
    logic              timeout_err_q;
    logic [2:0]        req_q;
    logic [1:0]        ptr_q;
    logic [1:0]        sel_q;
    logic [WD_W-1:0]   wdog_q;
    logic [GAP_W-1:0]  gap_q;

    logic              sel_valid;
    logic [1:0]        sel_idx;
    logic              wdog_hit;
    logic              end_busy;
    logic [2:0]        served_mask;

    rr_select3 u_sel (
        .pend_i  (pend_q),
        .ptr_i   (ptr_q),
        .valid_o (sel_valid),
        .idx_o   (sel_idx)
    );

    assign wdog_hit = (wdog_q == WD_LAST);
    assign end_busy = (state_q == ST_BUSY) && (done || abort || wdog_hit);

    // cv bit order is reversed relative to pend bit order.
    assign served_mask = {cv_q[0], cv_q[1], cv_q[2]};

    // New edges are OR-ed in after the service clear, so a replay request wins.
    always_comb begin
        pend_d = (pend_q & ~(end_busy ? served_mask : 3'b000)) | (req & ~req_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cv_q          <= CV_NONE;
            busy_q        <= 1'b0;
            pend_q        <= 3'b000;
            timeout_err_q <= 1'b0;
            req_q         <= 3'b000;
            ptr_q         <= 2'd2;
            sel_q         <= 2'd0;
            wdog_q        <= '0;
            gap_q         <= '0;
        end else begin
            req_q  <= req;
            pend_q <= pend_d;
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        cv_q    <= cv_code(sel_idx);
                        sel_q   <= sel_idx;
                        busy_q  <= 1'b1;
                        wdog_q  <= '0;
                        state_q <= ST_BUSY;
                    end else begin
                        cv_q <= CV_NONE;
                    end
                end
                ST_BUSY: begin
                    if (end_busy) begin
                        if (!done && !abort) begin
                            timeout_err_q <= 1'b1;
                        end
                        cv_q    <= CV_NONE;
                        busy_q  <= 1'b0;
                        ptr_q   <= sel_q;
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cv_q    <= CV_NONE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cv          = cv_q;
    assign busy        = busy_q;
    assign pend        = pend_q;
    assign timeout_err = timeout_err_q;

endmodule
